// File: rtl/jive_uart_dbg_if.sv
// jive_uart_dbg_if: JiVe peripheral bus as seen from one initiator.
// master drives the access, slave answers with dtack/rdata.
interface jive_uart_dbg_if;
  logic        csel;
  logic        rden;
  logic        wren;
  logic [3:0]  bena;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        dtack;

  modport master (
    output csel, rden, wren, bena, addr, wdata,
    input  rdata, dtack
  );

  modport slave (
    input  csel, rden, wren, bena, addr, wdata,
    output rdata, dtack
  );
endinterface

// File: rtl/jive_uart_dbg.sv
// jive_uart_dbg: 8N1 command frames in, one 32-bit JiVe access out,
// status byte (plus read data) returned on the serial line.
module jive_uart_dbg #(
  parameter int BAUD_RATE = 2500,
  parameter int TIMEOUT   = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic uart_rxd,
  output logic uart_txd,
  output logic busy,
  jive_uart_dbg_if.master bus
);

  localparam logic [11:0] L_BIT  = 12'(BAUD_RATE - 1);
  localparam logic [11:0] L_HALF = 12'(BAUD_RATE / 2 - 1);
  localparam logic [15:0] L_TO   = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_st_t;

  typedef enum logic [2:0] {
    P_IDLE, P_ADDR, P_DATA, P_BUS, P_RESP
  } p_st_t;

  rx_st_t r_rx_st;
  rx_st_t w_rx_nxt;
  p_st_t  r_p_st;
  p_st_t  w_p_nxt;

  logic [2:0]  r_sync;
  logic        r_rx_d;
  logic [11:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_sh;

  logic        w_rx_in;
  logic        w_fall;
  logic        w_rx_tick;
  logic        w_byte_ok;
  logic        w_frm_err;

  logic        r_is_wr;
  logic [3:0]  r_cmd_bena;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_csel;
  logic        r_rden;
  logic        r_wren;
  logic [3:0]  r_bena;
  logic [15:0] r_to_cnt;
  logic [31:0] r_resp;
  logic [9:0]  r_tx_frame;
  logic [11:0] r_tx_cnt;
  logic [3:0]  r_tx_bit;
  logic [2:0]  r_tx_left;
  logic        r_busy;

  logic        w_op_wr;
  logic        w_op_rd;
  logic        w_bena_nz;
  logic        w_cmd_ok;
  logic        w_last;
  logic        w_go;
  logic        w_bus_done;
  logic        w_rd_ok;
  logic        w_tx_end;
  logic [7:0]  w_status;

  assign w_rx_in   = r_sync[2];
  assign w_fall    = r_rx_d & ~w_rx_in;
  assign w_rx_tick = (r_rx_cnt == 12'd0);
  assign w_byte_ok = (r_rx_st == R_STOP) & w_rx_tick & w_rx_in;
  assign w_frm_err = (r_rx_st == R_STOP) & w_rx_tick & ~w_rx_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rx_st <= R_IDLE;
    else        r_rx_st <= w_rx_nxt;
  end

  always_comb begin
    w_rx_nxt = r_rx_st;
    unique case (r_rx_st)
      R_IDLE:  if (w_fall) w_rx_nxt = R_START;
      R_START: if (w_rx_tick)
                 w_rx_nxt = w_rx_in ? R_IDLE : R_DATA;
      R_DATA:  if (w_rx_tick && r_rx_bit == 3'd7)
                 w_rx_nxt = R_STOP;
      R_STOP:  if (w_rx_tick) w_rx_nxt = R_IDLE;
      default: w_rx_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= 3'b111;
      r_rx_d   <= 1'b1;
      r_rx_cnt <= 12'd0;
      r_rx_bit <= 3'd0;
      r_rx_sh  <= 8'd0;
    end else begin
      r_sync <= {r_sync[1:0], uart_rxd};
      r_rx_d <= w_rx_in;
      if (r_rx_st == R_IDLE) begin
        if (w_fall) r_rx_cnt <= L_HALF;
      end else if (w_rx_tick) begin
        r_rx_cnt <= L_BIT;
        if (r_rx_st == R_DATA) begin
          r_rx_sh  <= {w_rx_in, r_rx_sh[7:1]};
          r_rx_bit <= r_rx_bit + 3'd1;
        end else begin
          r_rx_bit <= 3'd0;
        end
      end else begin
        r_rx_cnt <= r_rx_cnt - 12'd1;
      end
    end
  end

  assign w_op_wr   = (r_rx_sh[7:6] == 2'b10);
  assign w_op_rd   = (r_rx_sh[7:6] == 2'b01);
  assign w_bena_nz = |r_rx_sh[3:0];

  always_comb begin
    w_cmd_ok = 1'b0;
    unique case (1'b1)
      w_op_wr: w_cmd_ok = w_bena_nz;
      w_op_rd: w_cmd_ok = w_bena_nz;
      default: w_cmd_ok = 1'b0;
    endcase
  end

  assign w_last     = (r_byte_cnt == 2'd3);
  // dtack in the final timeout cycle still wins over the abort
  assign w_bus_done = (r_p_st == P_BUS) &
                      (bus.dtack | (r_to_cnt == L_TO));
  assign w_rd_ok    = bus.dtack & ~r_is_wr;
  assign w_status   = bus.dtack ? 8'h4B : 8'h45;
  assign w_tx_end   = (r_p_st == P_RESP) &
                      (r_tx_cnt == 12'd0) &
                      (r_tx_bit == 4'd9) &
                      (r_tx_left == 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_p_st <= P_IDLE;
    else        r_p_st <= w_p_nxt;
  end

  always_comb begin
    w_p_nxt = r_p_st;
    unique case (r_p_st)
      P_IDLE: if (w_byte_ok && w_cmd_ok) w_p_nxt = P_ADDR;
      P_ADDR: begin
        if (w_frm_err)
          w_p_nxt = P_IDLE;
        else if (w_byte_ok && w_last)
          w_p_nxt = r_is_wr ? P_DATA : P_BUS;
      end
      P_DATA: begin
        if (w_frm_err)
          w_p_nxt = P_IDLE;
        else if (w_byte_ok && w_last)
          w_p_nxt = P_BUS;
      end
      P_BUS:  if (w_bus_done) w_p_nxt = P_RESP;
      P_RESP: if (w_tx_end) w_p_nxt = P_IDLE;
      default: w_p_nxt = P_IDLE;
    endcase
  end

  assign w_go = (r_p_st != P_BUS) & (w_p_nxt == P_BUS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_wr    <= 1'b0;
      r_cmd_bena <= 4'd0;
      r_byte_cnt <= 2'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_csel     <= 1'b0;
      r_rden     <= 1'b0;
      r_wren     <= 1'b0;
      r_bena     <= 4'd0;
      r_to_cnt   <= 16'd0;
      r_resp     <= 32'd0;
      r_tx_frame <= 10'h3FF;
      r_tx_cnt   <= 12'd0;
      r_tx_bit   <= 4'd0;
      r_tx_left  <= 3'd0;
      r_busy     <= 1'b0;
    end else begin
      r_busy <= (w_p_nxt != P_IDLE);
      if (r_p_st == P_IDLE && w_p_nxt == P_ADDR) begin
        r_is_wr    <= r_rx_sh[7];
        r_cmd_bena <= r_rx_sh[3:0];
        r_byte_cnt <= 2'd0;
      end
      if (w_byte_ok && r_p_st == P_ADDR) begin
        r_addr     <= {r_addr[23:0], r_rx_sh};
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      if (w_byte_ok && r_p_st == P_DATA) begin
        r_wdata    <= {r_wdata[23:0], r_rx_sh};
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      if (w_go) begin
        r_csel   <= 1'b1;
        r_rden   <= ~r_is_wr;
        r_wren   <= r_is_wr;
        r_bena   <= r_cmd_bena;
        r_to_cnt <= 16'd0;
      end
      if (r_p_st == P_BUS) begin
        if (w_bus_done) begin
          r_csel     <= 1'b0;
          r_rden     <= 1'b0;
          r_wren     <= 1'b0;
          r_bena     <= 4'd0;
          r_tx_frame <= {1'b1, w_status, 1'b0};
          r_tx_cnt   <= L_BIT;
          r_tx_bit   <= 4'd0;
          r_tx_left  <= w_rd_ok ? 3'd4 : 3'd0;
          if (w_rd_ok) r_resp <= bus.rdata;
        end else begin
          r_to_cnt <= r_to_cnt + 16'd1;
        end
      end
      // next byte is loaded as its start bit, so frames run gap-free
      if (r_p_st == P_RESP) begin
        if (r_tx_cnt != 12'd0) begin
          r_tx_cnt <= r_tx_cnt - 12'd1;
        end else begin
          r_tx_cnt <= L_BIT;
          if (r_tx_bit == 4'd9) begin
            if (r_tx_left != 3'd0) begin
              r_tx_frame <= {1'b1, r_resp[31:24], 1'b0};
              r_resp     <= {r_resp[23:0], 8'h00};
              r_tx_left  <= r_tx_left - 3'd1;
              r_tx_bit   <= 4'd0;
            end
          end else begin
            r_tx_frame <= {1'b1, r_tx_frame[9:1]};
            r_tx_bit   <= r_tx_bit + 4'd1;
          end
        end
      end
    end
  end

  assign uart_txd  = r_tx_frame[0];
  assign busy      = r_busy;
  assign bus.csel  = r_csel;
  assign bus.rden  = r_rden;
  assign bus.wren  = r_wren;
  assign bus.bena  = r_bena;
  assign bus.addr  = r_addr;
  assign bus.wdata = r_wdata;

endmodule

// File: tb/tb_jive_uart_dbg.sv
// tb_jive_uart_dbg: scoreboard bench for the UART debug bridge.
// Expected bus accesses and TX bytes are queued as frames are sent.
`timescale 1ns/1ps
module tb_jive_uart_dbg;

  localparam int B  = 16;
  localparam int TO = 8;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bena;
    int          len;
    bit          chk_len;
  } acc_t;

  typedef struct {
    logic [7:0] data;
    bit         b2b;
    bit         last;
  } txe_t;

  logic clk;
  logic rst_n;
  logic uart_rxd;
  logic uart_txd;
  logic busy;

  jive_uart_dbg_if bus_if();

  jive_uart_dbg #(
    .BAUD_RATE(B),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .uart_rxd(uart_rxd),
    .uart_txd(uart_txd),
    .busy(busy),
    .bus(bus_if)
  );

  int n_chk;
  int n_err;
  int cyc;
  int dly;
  int rcnt;
  int quiet_hits;
  bit quiet_win;
  logic [31:0] rval;
  acc_t acc_q[$];
  txe_t tx_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_acc(input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be,
                          input int len, input bit cl);
    acc_t e;
    e.wr = wr; e.addr = a; e.wdata = d;
    e.bena = be; e.len = len; e.chk_len = cl;
    acc_q.push_back(e);
  endtask

  task automatic push_tx(input logic [7:0] d, input bit b2b,
                         input bit last);
    txe_t e;
    e.data = d; e.b2b = b2b; e.last = last;
    tx_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stopv,
                           input int stop_cyc);
    uart_rxd = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (B) @(negedge clk);
    end
    uart_rxd = stopv;
    repeat (stop_cyc) @(negedge clk);
    uart_rxd = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1, B);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy), 0);
    repeat (2 * B) @(negedge clk);
  endtask

  // responder: dtack after dly cycles of csel, never when dly < 0
  always @(negedge clk) begin
    if (bus_if.csel) begin
      if (rcnt == dly) begin
        bus_if.dtack = 1'b1;
        bus_if.rdata = rval;
      end else begin
        bus_if.dtack = 1'b0;
        bus_if.rdata = 32'hBAD0BAD0;
      end
      rcnt++;
    end else begin
      bus_if.dtack = 1'b0;
      bus_if.rdata = 32'hBAD0BAD0;
      rcnt = 0;
    end
  end

  always @(negedge clk)
    if (quiet_win && (busy || bus_if.csel || !uart_txd))
      quiet_hits++;

  initial begin : bus_mon
    acc_t cur;
    bit in_acc;
    int len;
    in_acc = 1'b0;
    len = 0;
    forever begin
      @(negedge clk);
      if (rst_n && bus_if.csel) begin
        if (!in_acc) begin
          chk("bus_expected", 32'(acc_q.size() != 0), 1);
          if (acc_q.size() != 0) begin
            cur = acc_q.pop_front();
            chk("bus_wren", 32'(bus_if.wren), 32'(cur.wr));
            chk("bus_rden", 32'(bus_if.rden), 32'(!cur.wr));
            chk("bus_addr", bus_if.addr, cur.addr);
            chk("bus_bena", 32'(bus_if.bena), 32'(cur.bena));
            if (cur.wr) chk("bus_wdata", bus_if.wdata, cur.wdata);
          end
          len = 0;
        end
        in_acc = 1'b1;
        len++;
      end else if (in_acc) begin
        in_acc = 1'b0;
        if (rst_n && cur.chk_len) begin
          chk("strobe_len", len, cur.len);
          chk("bena_drop", 32'(bus_if.bena), 0);
          chk("rden_drop", 32'(bus_if.rden | bus_if.wren), 0);
        end
      end
    end
  end

  initial begin : tx_mon
    txe_t e;
    logic [7:0] b;
    logic st, sp;
    int t0, last_t0;
    last_t0 = 0;
    forever begin
      @(negedge clk);
      if (rst_n && uart_txd === 1'b0) begin
        t0 = cyc;
        repeat (B / 2) @(negedge clk);
        st = uart_txd;
        for (int k = 0; k < 8; k++) begin
          repeat (B) @(negedge clk);
          b[k] = uart_txd;
        end
        repeat (B) @(negedge clk);
        sp = uart_txd;
        chk("tx_expected", 32'(tx_q.size() != 0), 1);
        if (tx_q.size() != 0) begin
          e = tx_q.pop_front();
          chk("tx_start", 32'(st), 0);
          chk("tx_byte", 32'(b), 32'(e.data));
          chk("tx_stop", 32'(sp), 1);
          if (e.b2b) chk("tx_gap", t0 - last_t0, 10 * B);
          if (e.last) begin
            repeat (B / 2 - 1) @(negedge clk);
            chk("busy_hold", 32'(busy), 1);
            @(negedge clk);
            chk("busy_fall", 32'(busy), 0);
          end
        end
        last_t0 = t0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time limit reached, n_err %0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_err = 0; cyc = 0;
    dly = -1; rcnt = 0; rval = 32'h0;
    quiet_hits = 0; quiet_win = 1'b0;
    bus_if.dtack = 1'b0;
    bus_if.rdata = 32'h0;
    uart_rxd = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_txd", 32'(uart_txd), 1);
    chk("rst_csel", 32'(bus_if.csel), 0);
    chk("rst_strb", 32'({bus_if.rden, bus_if.wren}), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bena", 32'(bus_if.bena), 0);
    chk("rst_addr", bus_if.addr, 0);
    chk("rst_wdata", bus_if.wdata, 0);
    rst_n = 1'b1;
    repeat (2 * B) @(negedge clk);

    // write, dtack on fourth strobe cycle
    dly = 3;
    push_acc(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 4, 1'b1);
    push_tx(8'h4B, 1'b0, 1'b1);
    send_byte(8'h8F, 1'b1, B);
    send_word(32'h0000_1004);
    send_word(32'hDEAD_BEEF);
    wait_idle("idle_write");

    // read with 4-byte data response
    dly = 2;
    rval = 32'h1234_5678;
    push_acc(1'b0, 32'h0000_0020, 32'h0, 4'h1, 3, 1'b1);
    push_tx(8'h4B, 1'b0, 1'b0);
    push_tx(8'h12, 1'b1, 1'b0);
    push_tx(8'h34, 1'b1, 1'b0);
    push_tx(8'h56, 1'b1, 1'b0);
    push_tx(8'h78, 1'b1, 1'b1);
    send_byte(8'h41, 1'b1, B);
    send_word(32'h0000_0020);
    wait_idle("idle_read");

    // timeout: no dtack
    dly = -1;
    push_acc(1'b0, 32'h0000_0100, 32'h0, 4'h2, TO, 1'b1);
    push_tx(8'h45, 1'b0, 1'b1);
    send_byte(8'h42, 1'b1, B);
    send_word(32'h0000_0100);
    wait_idle("idle_timeout");

    // framing error aborts a write, following read runs
    dly = 0;
    rval = 32'hCAFE_F00D;
    send_byte(8'h8F, 1'b1, B);
    send_byte(8'h55, 1'b0, B);
    repeat (2 * B) @(negedge clk);
    chk("frm_busy", 32'(busy), 0);
    push_acc(1'b0, 32'h0000_00AA, 32'h0, 4'h4, 1, 1'b1);
    push_tx(8'h4B, 1'b0, 1'b0);
    push_tx(8'hCA, 1'b1, 1'b0);
    push_tx(8'hFE, 1'b1, 1'b0);
    push_tx(8'hF0, 1'b1, 1'b0);
    push_tx(8'h0D, 1'b1, 1'b1);
    send_byte(8'h44, 1'b1, B);
    send_word(32'h0000_00AA);
    wait_idle("idle_frm");

    // invalid opcode and zero byte enable are ignored
    quiet_win = 1'b1;
    send_byte(8'hC3, 1'b1, B);
    send_byte(8'h80, 1'b1, B);
    repeat (3 * B) @(negedge clk);
    quiet_win = 1'b0;
    chk("quiet", quiet_hits, 0);

    // reset while rden is high
    dly = -1;
    push_acc(1'b0, 32'h0000_3000, 32'h0, 4'h8, 0, 1'b0);
    send_byte(8'h48, 1'b1, B);
    send_byte(8'h00, 1'b1, B);
    send_byte(8'h00, 1'b1, B);
    send_byte(8'h30, 1'b1, B);
    send_byte(8'h00, 1'b1, 1);
    begin
      int n;
      n = 0;
      while (!bus_if.rden && n < 3 * B) begin
        @(negedge clk);
        n++;
      end
    end
    chk("rden_seen", 32'(bus_if.rden), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_csel", 32'(bus_if.csel), 0);
    chk("mr_rden", 32'(bus_if.rden), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_addr", bus_if.addr, 0);
    chk("mr_txd", 32'(uart_txd), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * B) @(negedge clk);
    chk("mr_idle_txd", 32'(uart_txd), 1);

    // normal write after reset
    dly = 1;
    push_acc(1'b1, 32'h0000_0008, 32'h0000_0055, 4'h3, 2, 1'b1);
    push_tx(8'h4B, 1'b0, 1'b1);
    send_byte(8'h83, 1'b1, B);
    send_word(32'h0000_0008);
    send_word(32'h0000_0055);
    wait_idle("idle_post_rst");

    repeat (4 * B) @(negedge clk);
    chk("acc_q_empty", acc_q.size(), 0);
    chk("tx_q_empty", tx_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
